grey_statis_ctrl: RTL and testbench

//  Frame-level sequencer and ROI gate in front of the grey statistics accumulator.
//  - Accepts a frame only while statistics are enabled.
//  - Latches ROI config at frame start; gates lval/data to the ROI window.
//  - Issues a done pulse after frame end; the accumulator uses it as its latch strobe.
//  - Sits between the sensor datapath and grey_statis; registers come from the register bank.

---
 rtl/grey_statis_ctrl_pkg.sv | 13 +
 rtl/grey_statis_ctrl_roi_window_gate.sv | 106 ++++++++++
 rtl/grey_statis_ctrl.sv | 114 +++++++++++
 tb/tb_grey_statis_ctrl.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/grey_statis_ctrl_pkg.sv
// Shared definitions for the grey statistics front end: register width and FSM state codes.
// The state codes are also decoded by the register bank, so their values are fixed.
package grey_statis_ctrl_pkg;

    localparam int unsigned GS_REG_WD = 32;
    localparam int unsigned STATE_W   = 2;

    localparam logic [STATE_W-1:0] ST_IDLE       = 2'd0;
    localparam logic [STATE_W-1:0] ST_WAIT_FRAME = 2'd1;
    localparam logic [STATE_W-1:0] ST_ACTIVE     = 2'd2;
    localparam logic [STATE_W-1:0] ST_DONE       = 2'd3;

endpackage

// File: rtl/grey_statis_ctrl_roi_window_gate.sv
// ROI window gate: column/line counters, window compares and the registered lval/data stage.
// Ports:
//   clk, reset                  clock, synchronous active-high reset
//   i_roi_load                  accepted frame start: latch ROI shadows, clear line counter
//   iv_off_x/width/off_y/height ROI configuration (raw register values)
//   i_active                    frame is being processed
//   i_lval, iv_pix_data         line valid and pixel data from the sensor path
//   o_lval, ov_pix_data         ROI-gated line valid and data, one clock later
module roi_window_gate
    import grey_statis_ctrl_pkg::*;
#(
    parameter int unsigned DAT_W  = 40,
    parameter int unsigned REG_WD = GS_REG_WD
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              i_roi_load,
    input  logic [REG_WD-1:0] iv_off_x,
    input  logic [REG_WD-1:0] iv_width,
    input  logic [REG_WD-1:0] iv_off_y,
    input  logic [REG_WD-1:0] iv_height,
    input  logic              i_active,
    input  logic              i_lval,
    input  logic [DAT_W-1:0]  iv_pix_data,
    output logic              o_lval,
    output logic [DAT_W-1:0]  ov_pix_data
);

    logic [REG_WD-1:0] col_cnt_q,  col_cnt_d;
    logic [REG_WD-1:0] line_cnt_q, line_cnt_d;
    logic [REG_WD-1:0] off_x_q,  off_x_d;
    logic [REG_WD-1:0] width_q,  width_d;
    logic [REG_WD-1:0] off_y_q,  off_y_d;
    logic [REG_WD-1:0] height_q, height_d;
    logic              lval_dly_q, lval_dly_d;
    logic              lval_q,   lval_d;
    logic [DAT_W-1:0]  pix_q,    pix_d;

    logic [REG_WD:0]   col_end;
    logic [REG_WD:0]   line_end;
    logic              col_hit;
    logic              line_hit;
    logic              hit;

    // Counters, shadows and window compare; ends are one bit wider so off+size never wraps.
    always_comb begin
        col_cnt_d  = '0;
        line_cnt_d = line_cnt_q;
        off_x_d    = off_x_q;
        width_d    = width_q;
        off_y_d    = off_y_q;
        height_d   = height_q;
        lval_dly_d = i_lval;

        if (i_lval) begin
            col_cnt_d = (col_cnt_q == '1) ? col_cnt_q : col_cnt_q + REG_WD'(1);
        end

        if (i_roi_load) begin
            line_cnt_d = '0;
            off_x_d    = iv_off_x;
            width_d    = iv_width;
            off_y_d    = iv_off_y;
            height_d   = iv_height;
        end else if (lval_dly_q && !i_lval && (line_cnt_q != '1)) begin
            line_cnt_d = line_cnt_q + REG_WD'(1);
        end

        col_end  = {1'b0, off_x_q} + {1'b0, width_q};
        line_end = {1'b0, off_y_q} + {1'b0, height_q};
        col_hit  = ({1'b0, col_cnt_q} >= {1'b0, off_x_q}) && ({1'b0, col_cnt_q} < col_end);
        line_hit = ({1'b0, line_cnt_q} >= {1'b0, off_y_q}) && ({1'b0, line_cnt_q} < line_end);
        hit      = i_lval && i_active && col_hit && line_hit;

        lval_d = hit;
        pix_d  = hit ? iv_pix_data : '0;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            col_cnt_q  <= '0;
            line_cnt_q <= '0;
            off_x_q    <= '0;
            width_q    <= '0;
            off_y_q    <= '0;
            height_q   <= '0;
            lval_dly_q <= 1'b0;
            lval_q     <= 1'b0;
            pix_q      <= '0;
        end else begin
            col_cnt_q  <= col_cnt_d;
            line_cnt_q <= line_cnt_d;
            off_x_q    <= off_x_d;
            width_q    <= width_d;
            off_y_q    <= off_y_d;
            height_q   <= height_d;
            lval_dly_q <= lval_dly_d;
            lval_q     <= lval_d;
            pix_q      <= pix_d;
        end
    end

    assign o_lval      = lval_q;
    assign ov_pix_data = pix_q;

endmodule

// File: rtl/grey_statis_ctrl.sv
// Frame sequencer and ROI gate in front of the grey statistics accumulator.
// Ports:
//   clk, reset              pixel clock, synchronous active-high reset
//   i_stat_en               statistics enable
//   iv_roi_*                ROI config, latched at each accepted frame start
//   i_fval, i_lval, iv_pix_data   sensor frame/line valid and pixel group
//   o_fval                  frame valid of accepted frames (rise clears the accumulator)
//   o_lval, ov_pix_data     ROI-gated line valid and data
//   o_stat_done             one-clock pulse after an accepted frame ends
//   o_busy                  accepted frame in progress
//   ov_frame_cnt            completed statistic frames
module grey_statis_ctrl
    import grey_statis_ctrl_pkg::*;
#(
    parameter int unsigned SENSOR_DAT_WIDTH = 10,
    parameter int unsigned CHANNEL_NUM      = 4,
    parameter int unsigned REG_WD           = GS_REG_WD
) (
    input  logic                                  clk,
    input  logic                                  reset,
    input  logic                                  i_stat_en,
    input  logic [REG_WD-1:0]                     iv_roi_offset_x,
    input  logic [REG_WD-1:0]                     iv_roi_width,
    input  logic [REG_WD-1:0]                     iv_roi_offset_y,
    input  logic [REG_WD-1:0]                     iv_roi_height,
    input  logic                                  i_fval,
    input  logic                                  i_lval,
    input  logic [SENSOR_DAT_WIDTH*CHANNEL_NUM-1:0] iv_pix_data,
    output logic                                  o_fval,
    output logic                                  o_lval,
    output logic [SENSOR_DAT_WIDTH*CHANNEL_NUM-1:0] ov_pix_data,
    output logic                                  o_stat_done,
    output logic                                  o_busy,
    output logic [REG_WD-1:0]                     ov_frame_cnt
);

    localparam int unsigned DAT_W = SENSOR_DAT_WIDTH * CHANNEL_NUM;

    logic [STATE_W-1:0] state_q, state_d;
    logic               fval_dly_q, fval_dly_d;
    logic               fval_q, fval_d;
    logic               done_q, done_d;
    logic               busy_q, busy_d;
    logic [REG_WD-1:0]  frame_cnt_q, frame_cnt_d;
    logic               roi_load;
    logic               active;

    // Next state and registered frame-level outputs; only a true fval rise starts a frame.
    always_comb begin
        state_d     = state_q;
        fval_dly_d  = i_fval;
        roi_load    = (state_q == ST_WAIT_FRAME) && i_stat_en && i_fval && !fval_dly_q;
        active      = (state_q == ST_ACTIVE);

        case (state_q)
            ST_IDLE:       if (i_stat_en) state_d = ST_WAIT_FRAME;
            ST_WAIT_FRAME: begin
                if (!i_stat_en)    state_d = ST_IDLE;
                else if (roi_load) state_d = ST_ACTIVE;
            end
            ST_ACTIVE:     if (!i_fval) state_d = ST_DONE;
            ST_DONE:       state_d = i_stat_en ? ST_WAIT_FRAME : ST_IDLE;
            default:       state_d = ST_IDLE;
        endcase

        fval_d      = i_fval && (roi_load || active);
        done_d      = active && !i_fval;
        busy_d      = (state_d == ST_ACTIVE);
        // Count is bumped together with the done pulse so the accumulator sees both at once.
        frame_cnt_d = done_d ? frame_cnt_q + REG_WD'(1) : frame_cnt_q;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            fval_dly_q  <= 1'b0;
            fval_q      <= 1'b0;
            done_q      <= 1'b0;
            busy_q      <= 1'b0;
            frame_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            fval_dly_q  <= fval_dly_d;
            fval_q      <= fval_d;
            done_q      <= done_d;
            busy_q      <= busy_d;
            frame_cnt_q <= frame_cnt_d;
        end
    end

    roi_window_gate #(
        .DAT_W  (DAT_W),
        .REG_WD (REG_WD)
    ) u_roi_window_gate (
        .clk         (clk),
        .reset       (reset),
        .i_roi_load  (roi_load),
        .iv_off_x    (iv_roi_offset_x),
        .iv_width    (iv_roi_width),
        .iv_off_y    (iv_roi_offset_y),
        .iv_height   (iv_roi_height),
        .i_active    (active),
        .i_lval      (i_lval),
        .iv_pix_data (iv_pix_data),
        .o_lval      (o_lval),
        .ov_pix_data (ov_pix_data)
    );

    assign o_fval       = fval_q;
    assign o_stat_done  = done_q;
    assign o_busy       = busy_q;
    assign ov_frame_cnt = frame_cnt_q;

endmodule

// File: tb/tb_grey_statis_ctrl.sv
// Self-checking bench for grey_statis_ctrl: per-cycle scoreboard of expected outputs,
// per-frame ROI pixel count/sum and frame counter checks.
module tb_grey_statis_ctrl;

    localparam int unsigned SDW = 10;
    localparam int unsigned CH  = 4;
    localparam int unsigned DW  = SDW * CH;
    localparam int unsigned RW  = 32;

    typedef struct packed {
        logic [RW-1:0] ox;
        logic [RW-1:0] w;
        logic [RW-1:0] oy;
        logic [RW-1:0] h;
    } roi_t;

    typedef struct packed {
        logic          fv;
        logic          lv;
        logic          done;
        logic          busy;
        logic [DW-1:0] data;
    } exp_t;

    typedef struct {
        logic en;
        roi_t r;
        int   lines;
        int   clks;
        logic acc;
        int   exp_lv;
    } vec_t;

    logic          clk = 1'b0;
    logic          reset;
    logic          i_stat_en;
    logic [RW-1:0] iv_roi_offset_x, iv_roi_width, iv_roi_offset_y, iv_roi_height;
    logic          i_fval, i_lval;
    logic [DW-1:0] iv_pix_data;
    logic          o_fval, o_lval, o_stat_done, o_busy;
    logic [DW-1:0] ov_pix_data;
    logic [RW-1:0] ov_frame_cnt;

    exp_t          sb_q[$];
    int            total = 0;
    int            bad   = 0;
    int            act_lv_cnt;
    logic [63:0]   act_sum;
    logic [RW-1:0] exp_cnt;
    vec_t          tbl[10];

    always #5 clk = ~clk;

    grey_statis_ctrl #(
        .SENSOR_DAT_WIDTH (SDW),
        .CHANNEL_NUM      (CH),
        .REG_WD           (RW)
    ) dut (
        .clk             (clk),
        .reset           (reset),
        .i_stat_en       (i_stat_en),
        .iv_roi_offset_x (iv_roi_offset_x),
        .iv_roi_width    (iv_roi_width),
        .iv_roi_offset_y (iv_roi_offset_y),
        .iv_roi_height   (iv_roi_height),
        .i_fval          (i_fval),
        .i_lval          (i_lval),
        .iv_pix_data     (iv_pix_data),
        .o_fval          (o_fval),
        .o_lval          (o_lval),
        .ov_pix_data     (ov_pix_data),
        .o_stat_done     (o_stat_done),
        .o_busy          (o_busy),
        .ov_frame_cnt    (ov_frame_cnt)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s t=%0t actual=%0h required=%0h", name, $time, act, exp);
        end
    endtask

    function automatic logic [DW-1:0] pix(input int ln, input int c);
        return DW'(ln * 97 + c * 13 + 5 + ln * c * 1024);
    endfunction

    function automatic bit in_rng(input int v, input logic [RW-1:0] off, input logic [RW-1:0] sz);
        longint lv, lo, ls;
        lv = longint'(v);
        lo = longint'(off);
        ls = longint'(sz);
        return (lv >= lo) && (lv < lo + ls);
    endfunction

    function automatic vec_t mk(input logic en, input roi_t r, input int lines, input int clks,
                                input logic acc, input int exp_lv);
        vec_t v;
        v.en = en; v.r = r; v.lines = lines; v.clks = clks; v.acc = acc; v.exp_lv = exp_lv;
        return v;
    endfunction

    // One clock: drive inputs, queue the output expected one clock later, compare after the edge.
    task automatic cyc(input logic fv, input logic lv, input logic [DW-1:0] d,
                       input logic efv, input logic elv, input logic edone, input logic ebusy);
        exp_t e;
        exp_t got;
        i_fval      = fv;
        i_lval      = lv;
        iv_pix_data = d;
        e.fv   = efv;
        e.lv   = elv;
        e.done = edone;
        e.busy = ebusy;
        e.data = elv ? d : '0;
        sb_q.push_back(e);
        @(posedge clk);
        #1;
        e   = sb_q.pop_front();
        got = {o_fval, o_lval, o_stat_done, o_busy, ov_pix_data};
        chk("cycle{fv,lv,done,busy,data}", 64'(got), 64'(e));
        if (o_lval) begin
            act_lv_cnt++;
            act_sum += 64'(ov_pix_data);
        end
    endtask

    task automatic set_roi(input roi_t r);
        iv_roi_offset_x = r.ox;
        iv_roi_width    = r.w;
        iv_roi_offset_y = r.oy;
        iv_roi_height   = r.h;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        cyc(1'b0, 1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("reset_frame_cnt", 64'(ov_frame_cnt), 64'd0);
        reset   = 1'b0;
        exp_cnt = '0;
    endtask

    // ev_kind at start of line ev_line: 1 toggle enable, 2 rewrite ROI regs with alt, 3 reset pulse.
    task automatic frame(input logic en, input roi_t r, input roi_t alt, input int lines,
                         input int clks, input logic acc_in, input int ev_line, input int ev_kind,
                         input int exp_lv);
        logic          acc;
        logic          hit;
        logic [63:0]   exp_sum;
        logic [DW-1:0] d;
        acc        = acc_in;
        exp_sum    = '0;
        act_lv_cnt = 0;
        act_sum    = '0;
        i_stat_en  = en;
        set_roi(r);
        repeat (3) cyc(1'b0, 1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b0);
        repeat (2) cyc(1'b1, 1'b0, '0, acc, 1'b0, 1'b0, acc);
        for (int ln = 0; ln < lines; ln++) begin
            if (ln == ev_line) begin
                case (ev_kind)
                    1: i_stat_en = ~en;
                    2: set_roi(alt);
                    3: begin
                        reset = 1'b1;
                        cyc(1'b1, 1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b0);
                        reset   = 1'b0;
                        acc     = 1'b0;
                        exp_cnt = '0;
                    end
                    default: ;
                endcase
            end
            for (int c = 0; c < clks; c++) begin
                d   = pix(ln, c);
                hit = acc && in_rng(c, r.ox, r.w) && in_rng(ln, r.oy, r.h);
                if (hit) exp_sum += 64'(d);
                cyc(1'b1, 1'b1, d, acc, hit, 1'b0, acc);
            end
            repeat (2) cyc(1'b1, 1'b0, '0, acc, 1'b0, 1'b0, acc);
        end
        cyc(1'b0, 1'b0, '0, 1'b0, 1'b0, acc, 1'b0);
        if (acc) exp_cnt = exp_cnt + RW'(1);
        chk("roi_lval_count", 64'(act_lv_cnt), 64'(exp_lv));
        chk("roi_pixel_sum", act_sum, exp_sum);
        chk("frame_cnt", 64'(ov_frame_cnt), 64'(exp_cnt));
    endtask

    initial begin
        roi_t ra;
        roi_t rf;
        ra = {32'd2, 32'd3, 32'd1, 32'd2};
        rf = {32'd0, 32'd8, 32'd0, 32'd4};

        tbl[0] = mk(1'b1, ra, 4, 8, 1'b1, 6);
        tbl[1] = mk(1'b1, {32'd2, 32'd0, 32'd0, 32'd4}, 4, 8, 1'b1, 0);
        tbl[2] = mk(1'b1, {32'd6, 32'd10, 32'd0, 32'd1}, 4, 8, 1'b1, 2);
        tbl[3] = mk(1'b1, {32'd0, 32'd8, 32'd0, 32'd0}, 4, 8, 1'b1, 0);
        tbl[4] = mk(1'b1, rf, 4, 8, 1'b1, 32);
        tbl[5] = mk(1'b0, rf, 4, 8, 1'b0, 0);
        tbl[6] = mk(1'b1, {32'd0, 32'd1, 32'd3, 32'd100}, 4, 8, 1'b1, 1);
        tbl[7] = mk(1'b1, {32'd0, 32'hFFFF_FFFF, 32'd1, 32'hFFFF_FFFF}, 4, 8, 1'b1, 24);
        tbl[8] = mk(1'b1, {32'hFFFF_FFFF, 32'd2, 32'd0, 32'd4}, 4, 8, 1'b1, 0);
        tbl[9] = mk(1'b1, {32'd3, 32'd2, 32'd2, 32'd2}, 5, 6, 1'b1, 4);

        reset       = 1'b1;
        i_stat_en   = 1'b0;
        i_fval      = 1'b0;
        i_lval      = 1'b0;
        iv_pix_data = '0;
        exp_cnt     = '0;
        act_lv_cnt  = 0;
        act_sum     = '0;
        set_roi('0);

        do_reset();

        foreach (tbl[i])
            frame(tbl[i].en, tbl[i].r, tbl[i].r, tbl[i].lines, tbl[i].clks, tbl[i].acc,
                  -1, 0, tbl[i].exp_lv);

        // Enable rising mid-frame: that frame is ignored, the next is processed.
        do_reset();
        frame(1'b0, ra, ra, 4, 8, 1'b0, 1, 1, 0);
        frame(1'b1, ra, ra, 4, 8, 1'b1, -1, 0, 6);
        chk("frame_cnt_after_en_rise", 64'(ov_frame_cnt), 64'd1);

        // Enable dropping in line 2: frame completes, following frame is not accepted.
        frame(1'b1, ra, ra, 4, 8, 1'b1, 2, 1, 6);
        frame(1'b0, ra, ra, 4, 8, 1'b0, -1, 0, 0);

        // ROI registers rewritten mid-frame: old window holds, next frame uses the new one.
        frame(1'b1, ra, rf, 4, 8, 1'b1, 1, 2, 6);
        frame(1'b1, rf, rf, 4, 8, 1'b1, -1, 0, 32);

        // Reset during line 1 of an active frame, then recovery on the next rise.
        frame(1'b1, ra, ra, 4, 8, 1'b1, 1, 3, 0);
        frame(1'b1, ra, ra, 4, 8, 1'b1, -1, 0, 6);
        chk("frame_cnt_after_reset", 64'(ov_frame_cnt), 64'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
